// File: rtl/shift_sequencer_if.sv
// Command/status bundle between the two requesters and shift_sequencer.
// master = requester side (tb/control logic), slave = the sequencer.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             req0;
    logic             req1;
    logic             dir0;
    logic             dir1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             fill0;
    logic             fill1;
    logic [1:0]       gnt;
    logic             owner;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;

    modport master (
        output req0, req1, dir0, dir1, cnt0, cnt1, fill0, fill1,
        input  gnt, owner, busy, done, Y
    );

    modport slave (
        input  req0, req1, dir0, dir1, cnt0, cnt1, fill0, fill1,
        output gnt, owner, busy, done, Y
    );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin two-source controller stepping a WIDTH-bit left/right shift register.
// Define SEQ_CLEAR_EN to clear Y on every grant; otherwise commands compose.
module shift_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               R,
    shift_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             owner_q, owner_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             grant0, grant1;

    // On a tie the source that is not the last owner wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = bus.req0 && (!bus.req1 || owner_q);
            grant1 = bus.req1 && (!bus.req0 || !owner_q);
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) state_q <= IDLE;
        else    state_q <= state_d;
    end

    // A zero count still spends one cycle in SHIFT (no shift), so done
    // lands one edge after the grant, like a single-shift command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant0 || grant1) state_d = SHIFT;
            SHIFT:   if (rem_q <= CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.done  = (state_q == DONE);
        bus.gnt   = gnt_q;
        bus.owner = owner_q;
        bus.Y     = y_q;
    end

    always_comb begin
        y_d     = y_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        owner_d = owner_q;
        gnt_d   = '0;
        if (grant0) begin
            gnt_d   = 2'b01;
            owner_d = 1'b0;
            dir_d   = bus.dir0;
            rem_d   = bus.cnt0;
            fill_d  = bus.fill0;
        end else if (grant1) begin
            gnt_d   = 2'b10;
            owner_d = 1'b1;
            dir_d   = bus.dir1;
            rem_d   = bus.cnt1;
            fill_d  = bus.fill1;
        end
`ifdef SEQ_CLEAR_EN
        if (grant0 || grant1) y_d = '0;
`else
`endif
        if (state_q == SHIFT && rem_q != '0) begin
            if (dir_q) y_d = {fill_q, y_q[WIDTH-1:1]};
            else       y_d = {y_q[WIDTH-2:0], fill_q};
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            y_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            owner_q <= 1'b1;
            gnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (default build or SEQ_CLEAR_EN).
module tb_shift_sequencer;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef SEQ_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic R;
    int   checks   = 0;
    int   failures = 0;

    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        R = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.dir0 = 1'b0; bus.dir1 = 1'b0;
        bus.cnt0 = '0;   bus.cnt1 = '0;
        bus.fill0 = 1'b0; bus.fill1 = 1'b0;
        step; step;
        check("rst_y",     32'(bus.Y),     32'h0);
        check("rst_gnt",   32'(bus.gnt),   32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_done",  32'(bus.done),  32'h0);
        check("rst_owner", 32'(bus.owner), 32'h1);
        R = 1'b1;
        step;

        // Left shift, count 3, fill 1 from 0000
        bus.dir0 = 1'b0; bus.cnt0 = 3'd3; bus.fill0 = 1'b1; bus.req0 = 1'b1;
        step;
        check("t1_gnt",   32'(bus.gnt),   32'h1);
        check("t1_busy",  32'(bus.busy),  32'h1);
        check("t1_owner", 32'(bus.owner), 32'h0);
        check("t1_done0", 32'(bus.done),  32'h0);
        bus.req0 = 1'b0;
        step;
        check("t1_y1",    32'(bus.Y),   32'h1);
        check("t1_gnt1",  32'(bus.gnt), 32'h0);
        check("t1_done1", 32'(bus.done), 32'h0);
        step;
        check("t1_y2",    32'(bus.Y),    32'h3);
        check("t1_done2", 32'(bus.done), 32'h0);
        step;
        check("t1_y3",    32'(bus.Y),    32'h7);
        check("t1_done3", 32'(bus.done), 32'h1);
        step;
        check("t1_done4", 32'(bus.done), 32'h0);
        check("t1_busy4", 32'(bus.busy), 32'h0);
        check("t1_y4",    32'(bus.Y),    32'h7);

        // Right shift, count 2, fill 0 from source 1 (composes on 0111)
        bus.dir1 = 1'b1; bus.cnt1 = 3'd2; bus.fill1 = 1'b0; bus.req1 = 1'b1;
        step;
        check("t2_gnt",   32'(bus.gnt),   32'h2);
        check("t2_owner", 32'(bus.owner), 32'h1);
        check("t2_y0",    32'(bus.Y),     CLR ? 32'h0 : 32'h7);
        bus.req1 = 1'b0;
        step;
        check("t2_y1",    32'(bus.Y),    CLR ? 32'h0 : 32'h3);
        check("t2_done1", 32'(bus.done), 32'h0);
        step;
        check("t2_y2",    32'(bus.Y),    CLR ? 32'h0 : 32'h1);
        check("t2_done2", 32'(bus.done), 32'h1);
        step;
        check("t2_done3", 32'(bus.done), 32'h0);

        // Tie straight after reset: source 0 first, then source 1
        R = 1'b0;
        step;
        R = 1'b1;
        bus.dir0 = 1'b0; bus.cnt0 = 3'd1; bus.fill0 = 1'b1;
        bus.dir1 = 1'b0; bus.cnt1 = 3'd1; bus.fill1 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step;
        check("t3_gnt_a", 32'(bus.gnt), 32'h1);
        bus.req0 = 1'b0;
        step;
        check("t3_y_a",    32'(bus.Y),    32'h1);
        check("t3_done_a", 32'(bus.done), 32'h1);
        step;
        check("t3_idle_gnt",  32'(bus.gnt),  32'h0);
        check("t3_idle_busy", 32'(bus.busy), 32'h0);
        step;
        check("t3_gnt_b",   32'(bus.gnt),   32'h2);
        check("t3_owner_b", 32'(bus.owner), 32'h1);
        bus.req1 = 1'b0;
        step;
        check("t3_y_b",    32'(bus.Y),    CLR ? 32'h0 : 32'h2);
        check("t3_done_b", 32'(bus.done), 32'h1);
        step;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step;
        check("t3_gnt_c",   32'(bus.gnt),   32'h1);
        check("t3_owner_c", 32'(bus.owner), 32'h0);
        bus.req0 = 1'b0;
        step;
        check("t3_y_c", 32'(bus.Y), CLR ? 32'h1 : 32'h5);
        step; step;
        check("t3_gnt_d", 32'(bus.gnt), 32'h2);
        bus.req1 = 1'b0;
        step;
        check("t3_y_d", 32'(bus.Y), CLR ? 32'h0 : 32'hA);
        step;

        // Preload a nonzero pattern, then a single left shift fill 1
        bus.dir0 = 1'b0; bus.cnt0 = 3'd2; bus.fill0 = 1'b1; bus.req0 = 1'b1;
        step;
        bus.req0 = 1'b0;
        step; step; step;
        check("t6_pre_y", 32'(bus.Y), CLR ? 32'h3 : 32'hB);
        bus.cnt0 = 3'd1; bus.req0 = 1'b1;
        step;
        bus.req0 = 1'b0;
        step;
        check("t6_y",    32'(bus.Y),    CLR ? 32'h1 : 32'h7);
        check("t6_done", 32'(bus.done), 32'h1);
        step;

        // Zero count: no shift, done one edge after the grant
        bus.cnt0 = 3'd0; bus.req0 = 1'b1;
        step;
        check("t4z_gnt",  32'(bus.gnt),  32'h1);
        check("t4z_done0", 32'(bus.done), 32'h0);
        bus.req0 = 1'b0;
        step;
        check("t4z_done1", 32'(bus.done), 32'h1);
        check("t4z_y",     32'(bus.Y),    CLR ? 32'h0 : 32'h7);
        step;
        check("t4z_done2", 32'(bus.done), 32'h0);
        check("t4z_busy2", 32'(bus.busy), 32'h0);

        // Overrun: 7 left shifts with fill 1 saturate to 1111
        bus.cnt0 = 3'd7; bus.fill0 = 1'b1; bus.req0 = 1'b1;
        step;
        bus.req0 = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step;
            check("t4o_done", 32'(bus.done), (i == 7) ? 32'h1 : 32'h0);
            if (i == 4 || i == 7) check("t4o_y", 32'(bus.Y), 32'hF);
        end
        step;
        check("t4o_done_end", 32'(bus.done), 32'h0);
        check("t4o_y_end",    32'(bus.Y),    32'hF);

        // Reset mid-SHIFT with two shifts remaining
        bus.cnt0 = 3'd4; bus.fill0 = 1'b0; bus.req0 = 1'b1;
        step;
        bus.req0 = 1'b0;
        step; step;
        check("t5_pre_y", 32'(bus.Y), CLR ? 32'h0 : 32'hC);
        R = 1'b0;
        #1;
        check("t5_y",     32'(bus.Y),     32'h0);
        check("t5_busy",  32'(bus.busy),  32'h0);
        check("t5_done",  32'(bus.done),  32'h0);
        check("t5_owner", 32'(bus.owner), 32'h1);
        step;
        check("t5_done_r", 32'(bus.done), 32'h0);
        step;
        R = 1'b1;
        bus.cnt0 = 3'd1; bus.cnt1 = 3'd1;
        bus.req1 = 1'b1; bus.req0 = 1'b1;
        step;
        check("t5_tie_gnt", 32'(bus.gnt), 32'h1);
        bus.req0 = 1'b0;
        step; step; step;
        check("t5_gnt_b", 32'(bus.gnt), 32'h2);
        bus.req1 = 1'b0;
        step; step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
